asmi_seq: RTL and testbench

ASMI_SEQ -- requirements
Module: asmi_seq

---
 rtl/asmi_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_asmi_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asmi_seq.sv
// asmi_seq -- byte-serial sequencer for an ASMI-style serial flash controller.
//
// Converts a block command (read / page program / sector erase) into a series
// of per-byte register transactions. Each byte is one data-register write
// {addr, byte}, then one command-register write {code}. The sequencer then
// waits for the controller to take the command (pending field clears), lets
// the status settle, and polls flash busy.
//
// Ports
//   CLK, RESETb                 clock, synchronous active-low reset
//   CMD_START/OP/ADDR/LEN       block request (OP 0=read 1=program 2=erase)
//   CMD_BUSY/DONE/ERR           status; ERR is valid with DONE and holds
//                               until the next accepted start
//   WR_REQ, WR_DATA             pop strobe / byte from a FWFT program source
//   RD_DATA, RD_VALID           read bytes, one strobe per byte
//   BUS_ADDR/DOUT/CEb/WEb/DIN   controller register port
//                               (DIN: [31] busy, [26:24] pending, [7:0] data)
//
// Optional feature: define ASMI_SEQ_VERIFY_EN to read back every programmed
// byte and flag a mismatch in CMD_ERR. The default build has no readback.
module asmi_seq #(
   parameter int SETTLE = 16,
   parameter int TMO_W  = 24
) (
   input  logic        CLK,
   input  logic        RESETb,
   input  logic        CMD_START,
   input  logic [1:0]  CMD_OP,
   input  logic [23:0] CMD_ADDR,
   input  logic [8:0]  CMD_LEN,
   output logic        CMD_BUSY,
   output logic        CMD_DONE,
   output logic        CMD_ERR,
   output logic        WR_REQ,
   input  logic [7:0]  WR_DATA,
   output logic [7:0]  RD_DATA,
   output logic        RD_VALID,
   output logic        BUS_ADDR,
   output logic [31:0] BUS_DOUT,
   output logic        BUS_CEb,
   output logic        BUS_WEb,
   input  logic [31:0] BUS_DIN
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0]   SET_LAST = SCW'(SETTLE - 1);
   // Expiring on 2^TMO_W-2 gives exactly 2^TMO_W-1 waiting cycles,
   // counting the ACK entry cycle as cycle 0.
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   localparam logic [1:0] OP_RD = 2'd0;
   localparam logic [1:0] OP_PG = 2'd1;
   localparam logic [1:0] OP_ER = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_ACK, S_SETTLE, S_POLL, S_NEXT, S_DONE
`ifdef ASMI_SEQ_VERIFY_EN
      , S_VRFY_LOAD, S_VRFY_ISSUE
`endif
   } state_t;

   state_t           state, nxt;
   logic [1:0]       op;
   logic [23:0]      addr;
   logic [8:0]       rem;
   logic             err;
   logic [SCW-1:0]   set_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       rd_data;
   logic             rd_valid;
`ifdef ASMI_SEQ_VERIFY_EN
   logic [7:0]       wbyte;
   logic             vphase;   // current ACK/SETTLE/POLL pass is the readback
`endif

   logic       flash_busy, tmo_exp, reject, waiting;
   logic [2:0] code;
   logic       unused_din;

   assign flash_busy = BUS_DIN[31];
   assign tmo_exp    = (tmo_cnt == TMO_LAST);
   assign waiting    = (state == S_ACK) || (state == S_SETTLE) || (state == S_POLL);
   assign code       = (op == OP_RD) ? 3'd2 : (op == OP_PG) ? 3'd3 : 3'd4;
   assign unused_din = ^{BUS_DIN[30:27], BUS_DIN[23:8]};

   // Erase ignores CMD_LEN; program must stay inside one 256-byte page.
   assign reject = (CMD_OP == 2'd3)
                || ((CMD_OP != OP_ER) && ((CMD_LEN == 9'd0) || (CMD_LEN > 9'd256)))
                || ((CMD_OP == OP_PG) && (({2'b00, CMD_ADDR[7:0]} + {1'b0, CMD_LEN}) > 10'd256));

   assign CMD_BUSY = (state != S_IDLE);
   assign CMD_ERR  = err;
   assign RD_DATA  = rd_data;
   assign RD_VALID = rd_valid;

   always_comb begin
      nxt      = state;
      BUS_ADDR = 1'b0;
      BUS_DOUT = 32'h0;
      BUS_CEb  = 1'b1;
      BUS_WEb  = 1'b1;
      WR_REQ   = 1'b0;
      CMD_DONE = 1'b0;
      case (state)
         S_IDLE:   if (CMD_START) nxt = reject ? S_DONE : S_LOAD;
         S_LOAD: begin
            BUS_CEb  = 1'b0;
            BUS_WEb  = 1'b0;
            BUS_DOUT = {addr, (op == OP_PG) ? WR_DATA : 8'h00};
            WR_REQ   = (op == OP_PG);
            nxt      = S_ISSUE;
         end
         S_ISSUE: begin
            BUS_ADDR = 1'b1;
            BUS_CEb  = 1'b0;
            BUS_WEb  = 1'b0;
            BUS_DOUT = {29'b0, code};
            nxt      = S_ACK;
         end
         S_ACK: begin
            if (BUS_DIN[26:24] == 3'd0) nxt = S_SETTLE;
            else if (tmo_exp)           nxt = S_DONE;
         end
         S_SETTLE: begin
            if (set_cnt == SET_LAST) nxt = S_POLL;
            else if (tmo_exp)        nxt = S_DONE;
         end
         S_POLL: begin
            if (!flash_busy) begin
`ifdef ASMI_SEQ_VERIFY_EN
               nxt = ((op == OP_PG) && !vphase) ? S_VRFY_LOAD : S_NEXT;
`else
               nxt = S_NEXT;
`endif
            end else if (tmo_exp) begin
               nxt = S_DONE;
            end
         end
         S_NEXT:   nxt = (rem == 9'd1) ? S_DONE : S_LOAD;
         S_DONE: begin
            CMD_DONE = 1'b1;
            nxt      = S_IDLE;
         end
`ifdef ASMI_SEQ_VERIFY_EN
         S_VRFY_LOAD: begin
            BUS_CEb  = 1'b0;
            BUS_WEb  = 1'b0;
            BUS_DOUT = {addr, 8'h00};
            nxt      = S_VRFY_ISSUE;
         end
         S_VRFY_ISSUE: begin
            BUS_ADDR = 1'b1;
            BUS_CEb  = 1'b0;
            BUS_WEb  = 1'b0;
            BUS_DOUT = {29'b0, 3'd2};
            nxt      = S_ACK;
         end
`endif
         default:  nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETb) begin
         state    <= S_IDLE;
         op       <= 2'd0;
         addr     <= 24'h0;
         rem      <= 9'd0;
         err      <= 1'b0;
         set_cnt  <= '0;
         tmo_cnt  <= '0;
         rd_data  <= 8'h0;
         rd_valid <= 1'b0;
`ifdef ASMI_SEQ_VERIFY_EN
         wbyte    <= 8'h0;
         vphase   <= 1'b0;
`endif
      end else begin
         state    <= nxt;
         rd_valid <= 1'b0;
         // Timeout abandons the rest of the block.
         if (waiting && (nxt == S_DONE)) err <= 1'b1;
         case (state)
            S_IDLE: begin
               if (CMD_START) begin
                  op   <= CMD_OP;
                  addr <= CMD_ADDR;
                  rem  <= (CMD_OP == OP_ER) ? 9'd1 : CMD_LEN;
                  err  <= reject;
`ifdef ASMI_SEQ_VERIFY_EN
                  vphase <= 1'b0;
`endif
               end
            end
`ifdef ASMI_SEQ_VERIFY_EN
            S_LOAD:       wbyte <= WR_DATA;
            S_VRFY_ISSUE: begin
               tmo_cnt <= '0;
               vphase  <= 1'b1;
            end
`endif
            S_ISSUE:  tmo_cnt <= '0;
            S_ACK: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               set_cnt <= '0;
            end
            S_SETTLE: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               set_cnt <= set_cnt + 1'b1;
            end
            S_POLL: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (!flash_busy) begin
                  if (op == OP_RD) begin
                     rd_data  <= BUS_DIN[7:0];
                     rd_valid <= 1'b1;
                  end
`ifdef ASMI_SEQ_VERIFY_EN
                  if (vphase && (BUS_DIN[7:0] != wbyte)) err <= 1'b1;
`endif
               end
            end
            S_NEXT: begin
               addr <= addr + 24'd1;
               rem  <= rem - 9'd1;
`ifdef ASMI_SEQ_VERIFY_EN
               vphase <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_asmi_seq.sv
// Bench for asmi_seq: a behavioural flash-controller model on the register
// port, a FWFT byte source, and a block-level reference that lists the bus
// writes, read bytes and error flag each command must produce.
module tb_asmi_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        start;
   logic [1:0]  op;
   logic [23:0] addr;
   logic [8:0]  len;
   logic        busy, done, err, wr_req, rd_valid, baddr, ceb, web;
   logic [7:0]  wr_data, rd_data;
   logic [31:0] dout, din;

   logic        t_start;
   logic [1:0]  t_op;
   logic [23:0] t_addr;
   logic [8:0]  t_len;
   logic        t_busy, t_done, t_err, t_wr_req, t_rd_valid, t_baddr, t_ceb, t_web;
   logic [7:0]  t_rd_data;
   logic [31:0] t_dout;
   logic [31:0] t_din;
   logic [7:0]  t_wr_data;
   assign t_din     = 32'h8000_0000;   // flash busy stuck high, nothing pending
   assign t_wr_data = 8'h00;

   asmi_seq u_dut (
      .CLK(clk), .RESETb(rstn),
      .CMD_START(start), .CMD_OP(op), .CMD_ADDR(addr), .CMD_LEN(len),
      .CMD_BUSY(busy), .CMD_DONE(done), .CMD_ERR(err),
      .WR_REQ(wr_req), .WR_DATA(wr_data), .RD_DATA(rd_data), .RD_VALID(rd_valid),
      .BUS_ADDR(baddr), .BUS_DOUT(dout), .BUS_CEb(ceb), .BUS_WEb(web), .BUS_DIN(din)
   );

   asmi_seq #(.SETTLE(16), .TMO_W(8)) u_tmo (
      .CLK(clk), .RESETb(rstn),
      .CMD_START(t_start), .CMD_OP(t_op), .CMD_ADDR(t_addr), .CMD_LEN(t_len),
      .CMD_BUSY(t_busy), .CMD_DONE(t_done), .CMD_ERR(t_err),
      .WR_REQ(t_wr_req), .WR_DATA(t_wr_data), .RD_DATA(t_rd_data), .RD_VALID(t_rd_valid),
      .BUS_ADDR(t_baddr), .BUS_DOUT(t_dout), .BUS_CEb(t_ceb), .BUS_WEb(t_web), .BUS_DIN(t_din)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // FWFT program-byte source
   logic [7:0] wbuf [0:255];
   logic [7:0] wr_idx = 8'd0;
   always @(posedge clk) if (wr_req) wr_idx <= wr_idx + 8'd1;
   assign wr_data = wbuf[wr_idx];

   // Flash controller model: pending for 3 cycles after a command write,
   // then busy for busy_len+1 cycles. Unprogrammed bytes read as A0+addr[7:0];
   // the most recently programmed byte reads back (optionally bit-0 flipped).
   int          busy_len = 3;
   logic        corrupt  = 1'b0;
   logic [2:0]  m_pend   = 3'd0;
   logic        m_busy   = 1'b0;
   int          m_cnt    = 0;
   logic [23:0] m_addr   = 24'h0;
   logic [7:0]  m_byte   = 8'h0;
   logic [7:0]  m_rd     = 8'h0;
   logic [23:0] m_paddr  = 24'h0;
   logic [7:0]  m_pbyte  = 8'h0;
   logic        m_pvalid = 1'b0;
   assign din = {m_busy, 4'b0, m_pend, 16'h0, m_rd};

   always @(posedge clk) begin
      if (!ceb && !web && !baddr) begin
         m_addr <= dout[31:8];
         m_byte <= dout[7:0];
      end
      if (!ceb && !web && baddr) begin
         m_pend <= dout[2:0];
         m_cnt  <= 2;
      end else if (m_pend != 3'd0) begin
         if (m_cnt == 0) begin
            m_pend <= 3'd0;
            m_busy <= 1'b1;
            m_cnt  <= busy_len;
            if (m_pend == 3'd2)
               m_rd <= (m_pvalid && m_addr == m_paddr) ? (m_pbyte ^ {7'b0, corrupt})
                                                       : (8'hA0 + m_addr[7:0]);
            if (m_pend == 3'd3) begin
               m_paddr  <= m_addr;
               m_pbyte  <= m_byte;
               m_pvalid <= 1'b1;
            end
         end else m_cnt <= m_cnt - 1;
      end else if (m_busy) begin
         if (m_cnt == 0) m_busy <= 1'b0;
         else            m_cnt  <= m_cnt - 1;
      end
   end

   // Monitors (sampled mid-cycle)
   logic [32:0] bus_q [$];
   logic [7:0]  rd_q  [$];
   int          done_cnt = 0, wr_cnt = 0;
   logic        err_at_done = 1'b0;
   always @(negedge clk) begin
      if (!ceb && !web) bus_q.push_back({baddr, dout});
      if (rd_valid) rd_q.push_back(rd_data);
      if (wr_req) wr_cnt++;
      if (done) begin
         done_cnt++;
         err_at_done = err;
      end
   end

   int   t_strb = 0, t_issue_cyc = 0, t_done_cnt = 0, t_done_cyc = 0;
   logic t_err_at_done = 1'b0;
   always @(negedge clk) begin
      if (!t_ceb && !t_web) begin
         t_strb++;
         if (t_baddr) t_issue_cyc = cyc;
      end
      if (t_done) begin
         t_done_cnt++;
         t_done_cyc = cyc;
         t_err_at_done = t_err;
      end
   end

   int last_cycles = 0;

   task automatic pulse_start(input logic [1:0] o, input logic [23:0] a, input logic [8:0] l);
      @(posedge clk); #1;
      start = 1'b1; op = o; addr = a; len = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_cmd(input string nm, input logic [1:0] o, input logic [23:0] a,
                          input logic [8:0] l, input bit vfail);
      logic [32:0] eb [$];
      logic [7:0]  er [$];
      logic [23:0] ai;
      logic [7:0]  base;
      bit          rej;
      int          n, b0, r0, d0, w0, c0;
      rej  = (o == 2'd3) || (o != 2'd2 && (l == 0 || l > 256))
          || (o == 2'd1 && (int'(a[7:0]) + int'(l) > 256));
      base = wr_idx;
      n    = rej ? 0 : ((o == 2'd2) ? 1 : int'(l));
      for (int i = 0; i < n; i++) begin
         ai = a + 24'(i);
         if (o == 2'd0) begin
            eb.push_back({1'b0, ai, 8'h00});
            eb.push_back({1'b1, 32'd2});
            er.push_back(8'hA0 + ai[7:0]);
         end else if (o == 2'd1) begin
            eb.push_back({1'b0, ai, wbuf[base + 8'(i)]});
            eb.push_back({1'b1, 32'd3});
`ifdef ASMI_SEQ_VERIFY_EN
            eb.push_back({1'b0, ai, 8'h00});
            eb.push_back({1'b1, 32'd2});
`endif
         end else begin
            eb.push_back({1'b0, ai, 8'h00});
            eb.push_back({1'b1, 32'd4});
         end
      end
      b0 = bus_q.size(); r0 = rd_q.size(); d0 = done_cnt; w0 = wr_cnt; c0 = cyc;
      pulse_start(o, a, l);
      chk({nm, "/busy_after_start"}, 64'(busy), 64'(1));
      if (rej) chk({nm, "/reject_done_next"}, 64'(done), 64'(1));
      while (done_cnt == d0 && cyc - c0 < 3000) begin
         @(posedge clk); #1;
      end
      last_cycles = cyc - c0;
      @(posedge clk); #1;
      chk({nm, "/done_pulses"}, 64'(done_cnt - d0), 64'(1));
      chk({nm, "/idle_after"}, 64'(busy), 64'(0));
      chk({nm, "/err"}, 64'(err_at_done), 64'(rej || vfail));
      chk({nm, "/n_bus"}, 64'(bus_q.size() - b0), 64'(eb.size()));
      for (int i = 0; i < eb.size() && b0 + i < bus_q.size(); i++)
         chk({nm, "/bus"}, 64'(bus_q[b0 + i]), 64'(eb[i]));
      chk({nm, "/n_rd"}, 64'(rd_q.size() - r0), 64'(er.size()));
      for (int i = 0; i < er.size() && r0 + i < rd_q.size(); i++)
         chk({nm, "/rd"}, 64'(rd_q[r0 + i]), 64'(er[i]));
      chk({nm, "/wr_req"}, 64'(wr_cnt - w0), 64'((o == 2'd1) ? n : 0));
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "/ctl"}, 64'({ceb, web, baddr, wr_req, rd_valid, busy, done, err}), 64'(8'b1100_0000));
      chk({nm, "/dout"}, 64'(dout), 64'(0));
      chk({nm, "/rd_data"}, 64'(rd_data), 64'(0));
      chk({nm, "/tmo_ctl"}, 64'({t_ceb, t_web, t_busy, t_done, t_err}), 64'(5'b11000));
   endtask

   initial begin
      int b0, d0, s0, td0, c0, dl;
      logic [1:0]  o;
      logic [23:0] a;
      logic [8:0]  l;
      for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
      rstn = 1'b0; start = 1'b0; op = 2'd0; addr = 24'h0; len = 9'd0;
      t_start = 1'b0; t_op = 2'd0; t_addr = 24'h0; t_len = 9'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rstn = 1'b1;

      // directed block commands
      run_cmd("read4", 2'd0, 24'h300000, 9'd4, 1'b0);
      run_cmd("prog2", 2'd1, 24'h6000FE, 9'd2, 1'b0);
      run_cmd("prog3_cross", 2'd1, 24'h6000FE, 9'd3, 1'b0);
      run_cmd("op3", 2'd3, 24'h000100, 9'd1, 1'b0);
      run_cmd("len0", 2'd0, 24'h300000, 9'd0, 1'b0);
      run_cmd("len257", 2'd0, 24'h300000, 9'd257, 1'b0);
      busy_len = 1000;
      run_cmd("erase", 2'd2, 24'h640000, 9'd0, 1'b0);
      chk("erase/busy_long", 64'(last_cycles >= 1000), 64'(1));
      busy_len = 3;
      run_cmd("read_wrap", 2'd0, 24'hFFFFFE, 9'd4, 1'b0);

      // reset in the middle of SETTLE of a 4-byte read
      b0 = bus_q.size(); d0 = done_cnt; c0 = cyc;
      pulse_start(2'd0, 24'h300010, 9'd4);
      while (bus_q.size() < b0 + 2 && cyc - c0 < 100) begin
         @(posedge clk); #1;
      end
      chk("mid_rst/issued", 64'(bus_q.size() - b0), 64'(2));
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      chk_reset("mid_rst");
      rstn = 1'b1;
      s0 = bus_q.size();
      repeat (40) @(posedge clk);
      #1;
      chk("mid_rst/no_strobe", 64'(bus_q.size() - s0), 64'(0));
      chk("mid_rst/no_done", 64'(done_cnt - d0), 64'(0));
      run_cmd("read_after_rst", 2'd0, 24'h300020, 9'd4, 1'b0);

      // timeout with busy stuck; a second start mid-operation is ignored
      s0 = t_strb; td0 = t_done_cnt;
      @(posedge clk); #1;
      t_start = 1'b1; t_op = 2'd0; t_addr = 24'h123456; t_len = 9'd1;
      @(posedge clk); #1;
      t_start = 1'b0;
      chk("tmo/busy", 64'(t_busy), 64'(1));
      repeat (60) @(posedge clk);
      #1;
      t_start = 1'b1; t_op = 2'd2; t_addr = 24'h640000;
      @(posedge clk); #1;
      t_start = 1'b0;
      c0 = cyc;
      while (t_done_cnt == td0 && cyc - c0 < 600) begin
         @(posedge clk); #1;
      end
      dl = t_done_cyc - t_issue_cyc;
      chk("tmo/done", 64'(t_done_cnt - td0), 64'(1));
      chk("tmo/err", 64'(t_err_at_done), 64'(1));
      chk("tmo/latency_le_256", 64'(dl <= 256 && dl >= 240), 64'(1));
      repeat (20) @(posedge clk);
      #1;
      chk("tmo/strobes", 64'(t_strb - s0), 64'(2));
      chk("tmo/idle", 64'(t_busy), 64'(0));

`ifdef ASMI_SEQ_VERIFY_EN
      corrupt = 1'b1;
      wbuf[wr_idx] = 8'h55;
      run_cmd("verify_bad", 2'd1, 24'h600010, 9'd1, 1'b1);
      corrupt = 1'b0;
`endif

      // randomized commands
      for (int k = 0; k < 16; k++) begin
         o = 2'($urandom_range(0, 3));
         l = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(257, 511))
                                          : 9'($urandom_range(0, 6));
         if (o == 2'd1)      a = {8'h60, 8'($urandom_range(0, 255)), 8'($urandom_range(240, 255))};
         else if (o == 2'd0) a = {8'h30, 16'($urandom)};
         else                a = {8'h64, 16'($urandom)};
         busy_len = $urandom_range(0, 20);
         run_cmd("rand", o, a, l, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
